// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder carry-select codes, op bit positions, sequencer states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  // Carry-in source for the shared adder
  localparam logic [1:0] CS_ZERO  = 2'd0;
  localparam logic [1:0] CS_ONE   = 2'd1;
  localparam logic [1:0] CS_CARRY = 2'd2;

  // Bit positions within the 2-bit op field
  localparam int OP_SUB       = 0;
  localparam int OP_USE_CARRY = 1;

  // Word sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

  // Carry seeded into word 0: subtract needs +1 for two's complement,
  // a chained add takes the external flag, a plain add starts at 0.
  function automatic logic seed_carry(input logic [1:0] op_f, input logic carry_flag);
    logic seed;
    seed = 1'b0;
    if (op_f[OP_SUB]) begin
      seed = 1'b1;
    end else if (op_f[OP_USE_CARRY]) begin
      seed = carry_flag;
    end
    return seed;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// Shared DATA_WIDTH-bit adder with selectable carry-in source.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module wide_add_sequencer_adder
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_lhs,
  input  logic [DATA_WIDTH-1:0] i_rhs,
  input  logic [1:0]            i_carry_select,
  input  logic                  i_carry_in,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_carry_out
);

  logic            w_cin;
  logic [DATA_WIDTH:0] w_full;

  // Pick the carry-in source and form the sum with its carry-out
  always_comb begin
    w_cin = 1'b0;
    case (i_carry_select)
      CS_ZERO:  w_cin = 1'b0;
      CS_ONE:   w_cin = 1'b1;
      CS_CARRY: w_cin = i_carry_in;
      default:  w_cin = 1'b0;
    endcase
    w_full = {1'b0, i_lhs} + {1'b0, i_rhs} + {{DATA_WIDTH{1'b0}}, w_cin};
  end

  assign o_sum       = w_full[DATA_WIDTH-1:0];
  assign o_carry_out = w_full[DATA_WIDTH];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-word add / add-with-carry / subtract, LS word first, through one shared adder.
// Latency: a word accepted at edge k is presented on outData from cycle k+1.
// Backpressure: single output register; input accepted only when it is empty or being drained.
module wide_add_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 4,
  parameter int CNT_WIDTH  = $clog2(MAX_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  wordCount,
  input  logic [1:0]            op,
  input  logic                  carryFlagIn,
  output logic                  busy,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inLhs,
  input  logic [DATA_WIDTH-1:0] inRhs,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  done,
  output logic                  carryFlagOut,
  output logic                  zeroFlag
);

  seq_state_e            r_state;
  seq_state_e            w_state_nxt;
  logic                  r_sub;
  logic [CNT_WIDTH-1:0]  r_word_count;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic                  r_carry;
  logic                  r_zero_acc;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_vld;
  logic                  r_carry_flag;
  logic                  r_zero_flag;

  logic                  w_in_rdy;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [DATA_WIDTH-1:0] w_rhs;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_cout;

  // Subtract is lhs + ~rhs + 1, the +1 coming from the seeded carry
  assign w_rhs = r_sub ? ~inRhs : inRhs;

  wide_add_sequencer_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .i_lhs          (inLhs),
    .i_rhs          (w_rhs),
    .i_carry_select (CS_CARRY),
    .i_carry_in     (r_carry),
    .o_sum          (w_sum),
    .o_carry_out    (w_cout)
  );

  assign w_in_hs  = inValid && w_in_rdy;
  assign w_out_hs = r_out_vld && outReady;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        // A same-cycle output handshake frees the register for the new word
        w_in_rdy = !r_out_vld || outReady;
        if (inValid && w_in_rdy && (r_idx == r_word_count)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_out_vld && outReady) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operation setup, per-word datapath, output register and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sub        <= 1'b0;
      r_word_count <= '0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_zero_acc   <= 1'b0;
      r_out_data   <= '0;
      r_out_vld    <= 1'b0;
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_sub        <= op[OP_SUB];
        r_word_count <= wordCount;
        r_carry      <= seed_carry(op, carryFlagIn);
        r_idx        <= '0;
        r_zero_acc   <= 1'b1;
      end
      if (w_in_hs) begin
        r_out_data <= w_sum;
        r_out_vld  <= 1'b1;
        r_carry    <= w_cout;
        r_zero_acc <= r_zero_acc && (w_sum == '0);
        r_idx      <= r_idx + CNT_WIDTH'(1);
      end else if (w_out_hs) begin
        r_out_vld <= 1'b0;
      end
      if (r_state == ST_DRAIN && w_out_hs) begin
        r_carry_flag <= r_carry;
        r_zero_flag  <= r_zero_acc;
      end
    end
  end

  assign inReady      = w_in_rdy;
  assign outValid     = r_out_vld;
  assign outData      = r_out_data;
  assign carryFlagOut = r_carry_flag;
  assign zeroFlag     = r_zero_flag;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed cases plus randomized ops against a big-integer model.
// Latency: n/a.
// Backpressure: exercises random and scripted outReady stalls.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  wordCount = '0;
  logic [1:0]  op = '0;
  logic        carryFlagIn = 1'b0;
  logic        busy;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inLhs = '0;
  logic [15:0] inRhs = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] outData;
  logic        done;
  logic        carryFlagOut;
  logic        zeroFlag;

  int n_vec = 0;
  int n_bad = 0;

  wide_add_sequencer #(
    .DATA_WIDTH(16),
    .MAX_WORDS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .wordCount   (wordCount),
    .op          (op),
    .carryFlagIn (carryFlagIn),
    .busy        (busy),
    .inValid     (inValid),
    .inReady     (inReady),
    .inLhs       (inLhs),
    .inRhs       (inRhs),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .done        (done),
    .carryFlagOut(carryFlagOut),
    .zeroFlag    (zeroFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Reference: treat operands as n*16-bit unsigned integers.
  function automatic void model(input int n, input logic [1:0] opc, input logic cin,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic c, output logic z);
    logic [79:0] m, va, vb, s;
    m  = (80'd1 << (16 * n)) - 80'd1;
    va = {16'h0, a} & m;
    vb = {16'h0, b} & m;
    if (opc[0]) begin
      s = (va - vb) & m;
      c = (va >= vb);
    end else begin
      s = va + vb + ((opc[1] && cin) ? 80'd1 : 80'd0);
      c = s[16 * n];
      s = s & m;
    end
    r = s[63:0];
    z = (r == 64'h0);
  endfunction

  // Runs one operation, collecting result words and timing observations.
  task automatic run_op(input int n, input logic [1:0] opc, input logic cin,
                        input logic [63:0] a, input logic [63:0] b,
                        input bit stall, input bit rnd,
                        output logic [63:0] res, output int nres, output int ndone,
                        output int done_gap, output logic cf, output logic zf,
                        output int stall_bad, output int stall_seen,
                        output int bubbles, output bit tmo);
    int sent, cyc, last_out, stall_left;
    logic [15:0] stall_dat;
    bit stalled_once;
    res = '0; nres = 0; ndone = 0; done_gap = -1; cf = 1'b0; zf = 1'b0;
    stall_bad = 0; stall_seen = 0; bubbles = 0; tmo = 1'b0;
    sent = 0; cyc = 0; last_out = 0; stall_left = 0; stall_dat = '0; stalled_once = 1'b0;
    @(negedge clk);
    start = 1'b1; wordCount = 2'(n - 1); op = opc; carryFlagIn = cin;
    @(negedge clk);
    start = 1'b0; carryFlagIn = $urandom_range(0, 1);
    forever begin
      outReady = (stall_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      inValid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      inLhs    = a[(sent % 4) * 16 +: 16];
      inRhs    = b[(sent % 4) * 16 +: 16];
      #1;
      if (done) begin
        ndone++;
        done_gap = cyc - last_out;
        cf = carryFlagOut;
        zf = zeroFlag;
      end
      if (stall_left > 0) begin
        stall_seen++;
        if (stall_left == 3) stall_dat = outData;
        if (inReady !== 1'b0 || outValid !== 1'b1 || outData !== stall_dat) stall_bad++;
        stall_left--;
      end
      if (nres > 0 && nres < n && !outValid) bubbles++;
      if (outValid && outReady) begin
        res[(nres % 4) * 16 +: 16] = outData;
        nres++;
        last_out = cyc;
        if (stall && !stalled_once && nres == 2) begin
          stall_left = 3;
          stalled_once = 1'b1;
        end
      end
      if (inValid && inReady) sent++;
      if (nres >= n && ndone > 0 && (cyc - last_out) >= 3) break;
      if (cyc >= 400) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (inReady !== 1'b0) begin n_bad++; $display("FAIL reset_inReady: got %b want 0", inReady); end
    n_vec++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL reset_outValid: got %b want 0", outValid); end
    n_vec++; if (outData !== 16'h0) begin n_bad++; $display("FAIL reset_outData: got %h want 0000", outData); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if ({carryFlagOut, zeroFlag} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {carryFlagOut, zeroFlag}); end
    @(negedge clk);
    reset = 1'b0;
    outReady = 1'b1;
  endtask

  task automatic test_one_word();
    @(negedge clk);
    start = 1'b1; wordCount = 2'd0; op = 2'd0; carryFlagIn = 1'b1;
    @(negedge clk);
    start = 1'b0; carryFlagIn = 1'b0;
    inValid = 1'b1; inLhs = 16'h1234; inRhs = 16'h0001; outReady = 1'b1;
    #1;
    n_vec++; if ({busy, inReady, outValid} !== 3'b110) begin n_bad++; $display("FAIL one_word_accept: got busy/inReady/outValid %b want 110", {busy, inReady, outValid}); end
    @(negedge clk);
    inValid = 1'b0;
    #1;
    n_vec++; if (outValid !== 1'b1 || outData !== 16'h1235) begin n_bad++; $display("FAIL one_word_data: got vld %b data %h want 1 1235", outValid, outData); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL one_word_early_done: got %b want 0", done); end
    @(negedge clk);
    #1;
    n_vec++; if (done !== 1'b1 || outValid !== 1'b0) begin n_bad++; $display("FAIL one_word_done: got done %b vld %b want 1 0", done, outValid); end
    n_vec++; if ({carryFlagOut, zeroFlag} !== 2'b00) begin n_bad++; $display("FAIL one_word_flags: got %b want 00", {carryFlagOut, zeroFlag}); end
    @(negedge clk);
    #1;
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL one_word_idle: got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_directed(input string name, input int n, input logic [1:0] opc, input logic cin,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp_res, input logic exp_c, input logic exp_z);
    logic [63:0] res; int nres, ndone, gap, sbad, sseen, bub; logic cf, zf; bit tmo;
    run_op(n, opc, cin, a, b, 1'b0, 1'b0, res, nres, ndone, gap, cf, zf, sbad, sseen, bub, tmo);
    n_vec++; if (tmo || nres != n) begin n_bad++; $display("FAIL %s_words: got %0d (timeout %0d) want %0d", name, nres, tmo, n); end
    n_vec++; if (res !== exp_res) begin n_bad++; $display("FAIL %s_result: got %h want %h", name, res, exp_res); end
    n_vec++; if (ndone != 1 || gap != 1) begin n_bad++; $display("FAIL %s_done: got %0d pulses gap %0d want 1 pulse gap 1", name, ndone, gap); end
    n_vec++; if ({cf, zf} !== {exp_c, exp_z}) begin n_bad++; $display("FAIL %s_flags: got c%b z%b want c%b z%b", name, cf, zf, exp_c, exp_z); end
  endtask

  task automatic test_stall();
    logic [63:0] res; int nres, ndone, gap, sbad, sseen, bub; logic cf, zf; bit tmo;
    run_op(4, 2'b01, 1'b0, 64'hDEADBEEFCAFE1234, 64'hDEADBEEFCAFE1234, 1'b1, 1'b0,
           res, nres, ndone, gap, cf, zf, sbad, sseen, bub, tmo);
    n_vec++; if (tmo || nres != 4 || res !== 64'h0) begin n_bad++; $display("FAIL stall_result: got %0d words %h want 4 words 0", nres, res); end
    n_vec++; if ({cf, zf} !== 2'b11) begin n_bad++; $display("FAIL stall_flags: got c%b z%b want c1 z1", cf, zf); end
    n_vec++; if (sseen != 3 || sbad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d stall cycles %0d bad want 3 and 0", sseen, sbad); end
    n_vec++; if (bub != 0) begin n_bad++; $display("FAIL stall_rate: got %0d bubbles want 0", bub); end
    n_vec++; if (ndone != 1 || gap != 1) begin n_bad++; $display("FAIL stall_done: got %0d pulses gap %0d want 1 and 1", ndone, gap); end
  endtask

  task automatic test_reset_mid();
    int acc, cyc, ndone;
    logic [63:0] res, er; int nres, nd, gap, sbad, sseen, bub; logic cf, zf, ec, ez; bit tmo;
    logic [63:0] a, b;
    @(negedge clk);
    start = 1'b1; wordCount = 2'd3; op = 2'd0; carryFlagIn = 1'b0;
    @(negedge clk);
    start = 1'b0; outReady = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 50) begin
      inValid = 1'b1; inLhs = 16'(acc + 1); inRhs = 16'h0100;
      #1;
      if (inReady) acc++;
      @(negedge clk);
      cyc++;
    end
    n_vec++; if (acc != 3) begin n_bad++; $display("FAIL rmid_feed: got %0d accepted want 3", acc); end
    inValid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if ({busy, outValid, done} !== 3'b000) begin n_bad++; $display("FAIL rmid_state: got busy/outValid/done %b want 000", {busy, outValid, done}); end
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (done) ndone++;
    end
    n_vec++; if (ndone != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", ndone); end
    a = {48'h0, 16'($urandom)}; b = {48'h0, 16'($urandom)};
    model(1, 2'b00, 1'b0, a, b, er, ec, ez);
    run_op(1, 2'b00, 1'b0, a, b, 1'b0, 1'b0, res, nres, nd, gap, cf, zf, sbad, sseen, bub, tmo);
    n_vec++; if (tmo || nres != 1 || res !== er) begin n_bad++; $display("FAIL rmid_fresh: got %0d words %h want 1 word %h", nres, res, er); end
    n_vec++; if (nd != 1 || {cf, zf} !== {ec, ez}) begin n_bad++; $display("FAIL rmid_fresh_flags: got %0d pulses c%b z%b want 1 c%b z%b", nd, cf, zf, ec, ez); end
  endtask

  task automatic test_random();
    logic [63:0] res, er, a, b; int n, nres, nd, gap, sbad, sseen, bub; logic cf, zf, ec, ez, cin; bit tmo;
    logic [1:0] opc;
    for (int t = 0; t < 40; t++) begin
      n   = $urandom_range(1, 4);
      opc = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = (t % 5 == 0) ? a : {$urandom, $urandom};
      if (t % 7 == 0) begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0; opc = 2'b10; cin = 1'b1; end
      model(n, opc, cin, a, b, er, ec, ez);
      run_op(n, opc, cin, a, b, 1'b0, 1'b1, res, nres, nd, gap, cf, zf, sbad, sseen, bub, tmo);
      n_vec++; if (tmo || nres != n || res !== er) begin n_bad++; $display("FAIL rand%0d_result: got %0d words %h want %0d words %h", t, nres, res, n, er); end
      n_vec++; if (nd != 1 || gap != 1) begin n_bad++; $display("FAIL rand%0d_done: got %0d pulses gap %0d want 1 and 1", t, nd, gap); end
      n_vec++; if ({cf, zf} !== {ec, ez}) begin n_bad++; $display("FAIL rand%0d_flags: got c%b z%b want c%b z%b", t, cf, zf, ec, ez); end
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_directed("add2", 2, 2'b00, 1'b0, 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001,
                  64'h0000_0000_0002_0000, 1'b0, 1'b0);
    test_directed("sub2", 2, 2'b01, 1'b0, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001,
                  64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
    test_directed("chain1", 1, 2'b10, 1'b1, 64'h0000_0000_0000_FFFF, 64'h0,
                  64'h0, 1'b1, 1'b1);
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Sequences the shared DATA_WIDTH-bit adder to perform multi-word add, add-with-carry and subtract on operands of 1..MAX_WORDS words.
- Operands arrive least-significant word first on a valid/ready input stream. Results leave on a valid/ready output stream.
- Final carry and zero flags are reported on completion.
- Sits between the instruction control unit and the ALU. It owns CarrySelect and the inter-word carry.

Parameters:
- DATA_WIDTH, 16, word width; must match the adder.
- MAX_WORDS, 4, maximum operand length in words; must be a power of 2, at least 2.
- CNT_WIDTH, $clog2(MAX_WORDS), width of the word counter and wordCount.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- wordCount  in  CNT_WIDTH  number of words minus 1; sampled with start.
- op  in  2  sampled with start. [0]=subtract; [1]=chain the external carry into word 0 (ignored when subtracting).
- carryFlagIn  in  1  external carry flag; sampled with start.
- busy  out  1  high whenever the block is not in IDLE.
- inValid  in  1  operand word valid.
- inReady  out  1  operand word accepted when inValid && inReady.
- inLhs  in  DATA_WIDTH  left operand word.
- inRhs  in  DATA_WIDTH  right operand word.
- outValid  out  1  result word valid.
- outReady  in  1  result word consumed when outValid && outReady.
- outData  out  DATA_WIDTH  result word.
- done  out  1  one-cycle completion pulse.
- carryFlagOut  out  1  final carry; for subtract, 1 = no borrow.
- zeroFlag  out  1  1 when all result words of the last operation were zero.

Behaviour:
- Reset values: state IDLE, busy 0, inReady 0, outValid 0, outData 0, done 0, carryFlagOut 0, zeroFlag 0, internal carry 0, word index 0.
- Reset mid-operation: the operation is abandoned, no done pulse, and any pending outValid is dropped.

State machine IDLE, FEED, DRAIN, FIN:
- IDLE:
  - On start, latch op and wordCount.
  - Seed the carry register: 1 if op[0]; else carryFlagIn if op[1]; else 0.
  - Clear the word index and set the zero accumulator to 1. Go to FEED.
- FEED:
  - inReady = !outValid || outReady; a single output register, no skid buffer.
  - On an input handshake:
    - Adder Lhs = inLhs; Rhs = op[0] ? ~inRhs : inRhs.
    - CarrySelect = 2 with carryIn = carry register.
    - Register the adder result into outData and set outValid at the next edge.
    - Carry register <= adder carryOut.
    - Zero accumulator &= (result == 0).
    - Index increments.
  - After the handshake where index == wordCount, go to DRAIN.
- DRAIN:
  - inReady = 0.
  - When the final output handshake occurs, load carryFlagOut and zeroFlag from the carry register and zero accumulator, then go to FIN.
- FIN: done = 1 for exactly one cycle, then IDLE. Flags hold until the next operation's FIN.

Timing and width rules:
- Latency: a word accepted at edge k has outValid high from cycle k+1.
- Throughput: one word per cycle while outReady stays high.
- Input and output handshakes in the same cycle are legal in FEED: the new result replaces the consumed one.
- outData is stable while outValid && !outReady.
- start while busy is ignored.
- wordCount = 0 gives a single-word operation.
- The index wraps naturally at MAX_WORDS; it never exceeds wordCount.
- Arithmetic is modulo 2^DATA_WIDTH per word. The carry chains only through the registered carry.
- The adder's aluAssert is tied 0; bus driving is outside this block.

Decomposition:
- Shared alu_pkg holds:
  - CarrySelect encodings: CS_ZERO=0, CS_ONE=1, CS_CARRY=2.
  - op bit positions OP_SUB=0 and OP_USE_CARRY=1.
  - the state encoding.
- Single sub-module: the existing adder, instantiated once with DATA_WIDTH passed through.

Test Plan:
- 1-word add, wordCount=0, op=0: 0x1234 + 0x0001 -> outData 0x1235 one cycle after acceptance; done one cycle after the output handshake; carryFlagOut 0, zeroFlag 0.
- 2-word add, words LS-first:
  - word 0: 0xFFFF + 0x0001 -> 0x0000;
  - word 1: 0x0001 + 0x0000 -> 0x0002.
  - carryFlagOut 0, zeroFlag 0.
- 2-word subtract, op=1, 0x00010000 - 0x00000001 -> words 0xFFFF, then 0x0000; carryFlagOut 1; zeroFlag 0.
- Carry chain, op=2, carryFlagIn=1, wordCount=0: 0xFFFF + 0x0000 -> 0x0000, carryFlagOut 1, zeroFlag 1.
- 4-word subtract of equal operands 0xDEADBEEFCAFE1234 -> four 0x0000 words; zeroFlag 1, carryFlagOut 1.
  - Hold outReady low 3 cycles after word 1: inReady low and outData stable throughout.
  - Resuming gives a full-rate finish.
- Assert reset for 1 cycle after word 2 of a 4-word add -> next cycle busy 0, outValid 0, no done.
  - A fresh 1-word add then completes normally.
